lfsr_stream_crypt: RTL and testbench

- Hardware LFSR stream-encryption engine. It replaces the Program #1 software loop (LFSR message encryption) with a parametrised sequencer.
- Sits beside TopLevel's data memory as a second bus master. It reads config words and the raw message, then writes the padded, encrypted block to the destination region.
- Generalised in character width, LFSR width, block length and memory map. Adds input sanitising (preamble clamp, zero-seed guard) and optional parity.

---
 rtl/lfsr_stream_crypt.sv | 161 ++++++++++++++++
 tb/tb_lfsr_stream_crypt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_crypt.sv
// lfsr_stream_crypt: LFSR stream-encryption sequencer acting as a second
// bus master beside the data memory. It fetches preamble length, taps and
// seed, then writes BLK_LEN encrypted characters: a preamble of pure LFSR
// output followed by the biased message XORed with the LFSR stream.
// Optional build macro: LFSR_PARITY_EN puts even parity of the cipher
// character in the output MSB; without it the MSB is always 0.
module lfsr_stream_crypt #(
  parameter int DATA_W   = 8,
  parameter int LFSR_W   = 7,
  parameter int BLK_LEN  = 64,
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 0,
  parameter int CFG_BASE = 61,
  parameter int DST_BASE = 64,
  parameter int PRE_MIN  = 10,
  parameter int PRE_MAX  = 26
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy
);

  localparam int IDX_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam int unsigned MSG_LEN = CFG_BASE - SRC_BASE;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG0, S_CFG1, S_CFG2, S_CFG3, S_RD, S_WR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                startPrev_q;
  logic [DATA_W-1:0]   pre_q, pre_d;
  logic [LFSR_W-1:0]   taps_q, taps_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [DATA_W-1:0]   preSafe;
  logic [LFSR_W-1:0]   seedSafe;
  logic [31:0]         charOff;
  logic                inMsg;
  logic [LFSR_W-1:0]   plain;
  logic [LFSR_W-1:0]   cipher;
  logic                parityBit;
  logic                feedback;

  // Config sanitising and the per-character datapath (message window, cipher).
  always_comb begin
    preSafe = mem_rdata;
    if (mem_rdata < DATA_W'(PRE_MIN)) preSafe = DATA_W'(PRE_MIN);
    else if (mem_rdata > DATA_W'(PRE_MAX)) preSafe = DATA_W'(PRE_MAX);
    seedSafe = mem_rdata[LFSR_W-1:0];
    if (seedSafe == '0) seedSafe = LFSR_W'(1);
    charOff  = 32'(idx_q) - 32'(pre_q);
    inMsg    = (32'(idx_q) >= 32'(pre_q)) && (charOff < MSG_LEN);
    plain    = inMsg ? mem_rdata[LFSR_W-1:0] : '0;
    cipher   = plain ^ lfsr_q;
    feedback = ^(lfsr_q & taps_q);
`ifdef LFSR_PARITY_EN
    parityBit = ^cipher;
`else
    parityBit = 1'b0;
`endif
  end

  // State and datapath registers; reset wins over everything, including a run.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      startPrev_q <= 1'b0;
      pre_q       <= '0;
      taps_q      <= '0;
      lfsr_q      <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      startPrev_q <= Start;
      pre_q       <= pre_d;
      taps_q      <= taps_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
    end
  end

  // Sequencer: next state, register updates and bus strobes (quiet during reset).
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    taps_d    = taps_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    Ack       = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (startPrev_q && !Start) state_d = S_CFG0;
      end
      S_CFG0: begin
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(CFG_BASE);
        state_d   = S_CFG1;
      end
      S_CFG1: begin
        pre_d     = preSafe;
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(CFG_BASE + 1);
        state_d   = S_CFG2;
      end
      S_CFG2: begin
        taps_d    = mem_rdata[LFSR_W-1:0];
        mem_rd_en = 1'b1;
        mem_addr  = ADDR_W'(CFG_BASE + 2);
        state_d   = S_CFG3;
      end
      S_CFG3: begin
        lfsr_d  = seedSafe;
        idx_d   = '0;
        state_d = S_RD;
      end
      S_RD: begin
        if (inMsg) begin
          mem_rd_en = 1'b1;
          mem_addr  = ADDR_W'(32'(SRC_BASE) + charOff);
        end
        state_d = S_WR;
      end
      S_WR: begin
        mem_wr_en = 1'b1;
        mem_addr  = ADDR_W'(32'(DST_BASE) + 32'(idx_q));
        mem_wdata = {parityBit, cipher};
        lfsr_d    = {lfsr_q[LFSR_W-2:0], feedback};
        idx_d     = idx_q + IDX_W'(1);
        state_d   = (idx_q == IDX_W'(BLK_LEN - 1)) ? S_DONE : S_RD;
      end
      S_DONE: begin
        Ack = 1'b1;
        if (Start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    if (Reset) begin
      Ack       = 1'b0;
      busy      = 1'b0;
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_crypt.sv
// Testbench for lfsr_stream_crypt: memory model, write scoreboard fed by a
// reference model of the cipher, and directed plus random runs.
module tb_lfsr_stream_crypt;

  localparam int BLK_LEN  = 64;
  localparam int SRC_BASE = 0;
  localparam int CFG_BASE = 61;
  localparam int DST_BASE = 64;
  localparam int PRE_MIN  = 10;
  localparam int PRE_MAX  = 26;
  localparam int MSG_LEN  = CFG_BASE - SRC_BASE;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wrEntry_t;

  logic       clock;
  logic       reset;
  logic       start;
  logic       ack;
  logic [7:0] memAddr;
  logic       memRdEn;
  logic [7:0] memRdata;
  logic       memWrEn;
  logic [7:0] memWdata;
  logic       busy;

  logic [7:0] srcMem [256];
  logic [7:0] dstMem [256];

  wrEntry_t expQ[$];
  int testsRun    = 0;
  int testsFailed = 0;
  int writeCount  = 0;

  lfsr_stream_crypt dut (
    .Clk       (clock),
    .Reset     (reset),
    .Start     (start),
    .Ack       (ack),
    .mem_addr  (memAddr),
    .mem_rd_en (memRdEn),
    .mem_rdata (memRdata),
    .mem_wr_en (memWrEn),
    .mem_wdata (memWdata),
    .busy      (busy)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: reads come from the source image, writes land in dstMem.
  always @(posedge clock) begin
    if (memRdEn) memRdata <= srcMem[memAddr];
    if (memWrEn) dstMem[memAddr] <= memWdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] withParity(input logic [6:0] c);
`ifdef LFSR_PARITY_EN
    return {^c, c};
`else
    return {1'b0, c};
`endif
  endfunction

  // Scoreboard side: every write the DUT makes is matched against the queue.
  always @(negedge clock) begin
    if (memWrEn) begin
      writeCount++;
      checkOutput("portClash", {31'd0, memRdEn}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedWrite", {31'd0, memWrEn}, 32'd0);
      end else begin
        wrEntry_t e;
        e = expQ.pop_front();
        checkOutput("wrAddr", {24'd0, memAddr}, {24'd0, e.addr});
        checkOutput("wrData", {24'd0, memWdata}, {24'd0, e.data});
      end
    end
  end

  // Reference model: pushes the expected write stream for one run.
  task automatic buildExpected(input int preRaw, input int tapsRaw, input int seedRaw);
    int pre;
    logic [6:0] lfsr;
    logic [6:0] taps;
    logic [6:0] plain;
    logic [6:0] c;
    int k;
    pre = preRaw & 255;
    if (pre < PRE_MIN) pre = PRE_MIN;
    if (pre > PRE_MAX) pre = PRE_MAX;
    lfsr = seedRaw[6:0];
    if (lfsr == 7'd0) lfsr = 7'd1;
    taps = tapsRaw[6:0];
    for (int i = 0; i < BLK_LEN; i++) begin
      k = i - pre;
      plain = (k >= 0 && k < MSG_LEN) ? srcMem[SRC_BASE + k][6:0] : 7'd0;
      c = plain ^ lfsr;
      expQ.push_back('{addr: 8'(DST_BASE + i), data: withParity(c)});
      lfsr = {lfsr[5:0], ^(lfsr & taps)};
    end
  endtask

  task automatic loadMessage(input logic [7:0] fill, input int len, input bit randomize);
    for (int a = 0; a < 256; a++) srcMem[a] = 8'h00;
    for (int a = 0; a < len; a++) srcMem[SRC_BASE + a] = randomize ? 8'($urandom) : fill;
  endtask

  // One run: configure, launch, optionally pulse Start or reset mid-run, then verify.
  task automatic applyStimulus(input string name, input int preRaw, input int tapsRaw,
                               input int seedRaw, input int pulseAt, input int resetAt);
    int cycles;
    int snapCount;
    srcMem[CFG_BASE]     = 8'(preRaw);
    srcMem[CFG_BASE + 1] = 8'(tapsRaw);
    srcMem[CFG_BASE + 2] = 8'(seedRaw);
    expQ.delete();
    buildExpected(preRaw, tapsRaw, seedRaw);
    writeCount = 0;
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clock);
      cycles++;
      #1;
      if (cycles == pulseAt) start = 1'b1;
      if (cycles == pulseAt + 1) start = 1'b0;
      if (cycles == resetAt) begin
        checkOutput($sformatf("%s/preResetWrites", name), writeCount, (resetAt - 4) / 2);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput($sformatf("%s/ackInReset", name), {31'd0, ack}, 32'd0);
        checkOutput($sformatf("%s/busyInReset", name), {31'd0, busy}, 32'd0);
        reset = 1'b0;
        expQ.delete();
        snapCount = writeCount;
        repeat (20) @(posedge clock);
        #1;
        checkOutput($sformatf("%s/postResetWrites", name), writeCount, snapCount);
        checkOutput($sformatf("%s/ackAfterReset", name), {31'd0, ack}, 32'd0);
        checkOutput($sformatf("%s/busyAfterReset", name), {31'd0, busy}, 32'd0);
        return;
      end
      if (ack) break;
    end
    checkOutput($sformatf("%s/ackCycle", name), cycles, 4 + 2 * BLK_LEN);
    checkOutput($sformatf("%s/writeCount", name), writeCount, BLK_LEN);
    checkOutput($sformatf("%s/sbEmpty", name), expQ.size(), 0);
    checkOutput($sformatf("%s/busyDone", name), {31'd0, busy}, 32'd0);
    start = 1'b1;
    @(posedge clock);
    #1;
    checkOutput($sformatf("%s/ackDrop", name), {31'd0, ack}, 32'd0);
    checkOutput($sformatf("%s/busyIdle", name), {31'd0, busy}, 32'd0);
  endtask

  task automatic checkPrefix(input string name, input int count);
    logic [6:0] lfsrRef [11];
    lfsrRef = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03, 7'h06, 7'h0C, 7'h18};
    for (int i = 0; i < count; i++)
      checkOutput($sformatf("%s/dst%0d", name, i), {24'd0, dstMem[DST_BASE + i]},
                  {24'd0, withParity(lfsrRef[i])});
  endtask

  // Main sequence of scenarios.
  initial begin
    start = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstAck", {31'd0, ack}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstRdEn", {31'd0, memRdEn}, 32'd0);
    checkOutput("rstWrEn", {31'd0, memWrEn}, 32'd0);
    checkOutput("rstAddr", {24'd0, memAddr}, 32'd0);
    checkOutput("rstWdata", {24'd0, memWdata}, 32'd0);
    reset = 1'b0;

    loadMessage(8'h00, 0, 1'b0);
    applyStimulus("zeroMsg", 10, 'h60, 1, -1, -1);
    checkPrefix("zeroMsg", 11);

    loadMessage(8'h20, 35, 1'b0);
    applyStimulus("atMsg", 10, 'h60, 1, -1, -1);
    checkPrefix("atMsg", 10);
    checkOutput("atMsg/dst10", {24'd0, dstMem[DST_BASE + 10]}, {24'd0, withParity(7'h38)});

    applyStimulus("preLowSeedZero", 5, 'h60, 0, -1, -1);
    checkPrefix("preLowSeedZero", 10);
    checkOutput("preLowSeedZero/dst10", {24'd0, dstMem[DST_BASE + 10]}, {24'd0, withParity(7'h38)});

    applyStimulus("preHigh", 40, 'h60, 1, -1, -1);

    loadMessage(8'h00, 0, 1'b0);
    applyStimulus("startPulse", 10, 'h60, 1, 20, -1);

    applyStimulus("midReset", 10, 'h60, 1, -1, 50);
    applyStimulus("afterReset", 10, 'h60, 1, -1, -1);
    checkPrefix("afterReset", 11);

    loadMessage(8'h00, MSG_LEN, 1'b1);
    applyStimulus("random", int'($urandom_range(0, 63)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), -1, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
